// File: rtl/spi_pkg.sv
// Shared constants and types for the Gigex SPI command responder.
package spi_pkg;

  localparam int unsigned WORD_BITS = 32;
  // Counter must reach WORD_BITS+1 so over-long frames stay distinguishable.
  localparam int unsigned CNT_BITS  = $clog2(WORD_BITS + 2);

  localparam logic [CNT_BITS-1:0] CNT_WORD = CNT_BITS'(WORD_BITS);
  localparam logic [CNT_BITS-1:0] CNT_MAX  = CNT_BITS'(WORD_BITS + 1);

  // Synchroniser reset values: CS idle high, SCK idle low.
  localparam logic CS_RST   = 1'b1;
  localparam logic SCK_RST  = 1'b0;
  localparam logic MOSI_RST = 1'b0;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StActive   = 2'd1,
    StDisarmed = 2'd2
  } state_e;

endpackage

// File: rtl/spi_cmd_slave_if.sv
// SPI pins plus command/response streams of the Gigex command port.
interface spi_cmd_slave_if;
  import spi_pkg::*;

  logic                 spi_cs;
  logic                 spi_sck;
  logic                 spi_mosi;
  logic                 spi_miso;
  logic [WORD_BITS-1:0] cmd_data;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [WORD_BITS-1:0] resp_data;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 err_frame;
  logic                 err_overrun;

  modport slave (
    input  spi_cs, spi_sck, spi_mosi, cmd_ready, resp_data, resp_valid,
    output spi_miso, cmd_data, cmd_valid, resp_ready, err_frame, err_overrun
  );

  modport master (
    output spi_cs, spi_sck, spi_mosi, cmd_ready, resp_data, resp_valid,
    input  spi_miso, cmd_data, cmd_valid, resp_ready, err_frame, err_overrun
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
module sync_2ff #(
  parameter logic RstVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops resolve metastability before use.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RstVal;
      q    <= RstVal;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_cmd_slave.sv
// Oversampling SPI responder: 32-bit commands in on MOSI, 32-bit responses out on MISO.
module spi_cmd_slave
  import spi_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  spi_cmd_slave_if.slave bus
);

  logic cs_s, sck_s, mosi_s;

  sync_2ff #(.RstVal(CS_RST))   u_sync_cs   (.clk(clk), .rst(rst), .d(bus.spi_cs),   .q(cs_s));
  sync_2ff #(.RstVal(SCK_RST))  u_sync_sck  (.clk(clk), .rst(rst), .d(bus.spi_sck),  .q(sck_s));
  sync_2ff #(.RstVal(MOSI_RST)) u_sync_mosi (.clk(clk), .rst(rst), .d(bus.spi_mosi), .q(mosi_s));

  logic                 cs_q, sck_q;
  logic [1:0]           settle_q;
  state_e               state_q, state_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [WORD_BITS-1:0] rx_q, rx_d, tx_q, tx_d, cmd_data_q, cmd_data_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic                 err_frame_q, err_frame_d, err_overrun_q, err_overrun_d;
  logic                 cs_fall, cs_rise, sck_rise, settled, resp_ready;

  assign cs_fall  = cs_q & ~cs_s;
  assign cs_rise  = ~cs_q & cs_s;
  assign sck_rise = ~sck_q & sck_s;
  // Synchronised CS is meaningful only once the reset value has flushed out.
  assign settled  = (settle_q == 2'd3);

  assign resp_ready = (state_q == StIdle) & settled & cs_s & ~cs_rise;

  assign bus.spi_miso    = tx_q[WORD_BITS-1];
  assign bus.cmd_data    = cmd_data_q;
  assign bus.cmd_valid   = cmd_valid_q;
  assign bus.resp_ready  = resp_ready;
  assign bus.err_frame   = err_frame_q;
  assign bus.err_overrun = err_overrun_q;

  // Edge-detect copies and post-reset settle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cs_q     <= CS_RST;
      sck_q    <= SCK_RST;
      settle_q <= 2'd0;
    end else begin
      cs_q  <= cs_s;
      sck_q <= sck_s;
      if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // FSM next state; a CS fall seen before settling means CS was already low at reset release.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (cs_fall) state_d = settled ? StActive : StDisarmed;
      StActive:   if (cs_rise) state_d = StIdle;
      StDisarmed: if (cs_rise) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  // Datapath next state: shifters, bit counter, command handshake, error pulses.
  always_comb begin
    cnt_d         = cnt_q;
    rx_d          = rx_q;
    tx_d          = tx_q;
    cmd_data_d    = cmd_data_q;
    cmd_valid_d   = cmd_valid_q;
    err_frame_d   = 1'b0;
    err_overrun_d = 1'b0;

    if (cmd_valid_q && bus.cmd_ready) cmd_valid_d = 1'b0;

    if ((state_q == StIdle) && cs_fall && settled) begin
      cnt_d = '0;
      rx_d  = '0;
    end

    if ((state_q == StActive) && !cs_s && sck_rise) begin
      rx_d = {rx_q[WORD_BITS-2:0], mosi_s};
      tx_d = {tx_q[WORD_BITS-2:0], 1'b0};
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end

    if ((state_q == StActive) && cs_rise) begin
      tx_d = '0;
      if (cnt_q == CNT_WORD) begin
        // A consume in the same cycle frees the slot, so the new word wins.
        if (cmd_valid_q && !bus.cmd_ready) begin
          err_overrun_d = 1'b1;
        end else begin
          cmd_data_d  = rx_q;
          cmd_valid_d = 1'b1;
        end
      end else begin
        err_frame_d = 1'b1;
      end
    end

    if (bus.resp_valid && resp_ready) tx_d = bus.resp_data;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      rx_q          <= '0;
      tx_q          <= '0;
      cmd_data_q    <= '0;
      cmd_valid_q   <= 1'b0;
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      rx_q          <= rx_d;
      tx_q          <= tx_d;
      cmd_data_q    <= cmd_data_d;
      cmd_valid_q   <= cmd_valid_d;
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
    end
  end

endmodule

// File: tb/tb_spi_cmd_slave.sv
// Directed self-checking bench for spi_cmd_slave acting as an SPI master and command consumer.
module tb_spi_cmd_slave;

  logic clk = 1'b0;
  logic rst;

  spi_cmd_slave_if bus ();

  spi_cmd_slave dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  int   n_cmd = 0;
  int   n_ferr = 0;
  int   n_oerr = 0;
  logic cv_prev = 1'b0;

  // Count command rises and error pulses, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.cmd_valid && !cv_prev) n_cmd <= n_cmd + 1;
    if (bus.err_frame) n_ferr <= n_ferr + 1;
    if (bus.err_overrun) n_oerr <= n_oerr + 1;
    cv_prev <= bus.cmd_valid;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic spi_start();
    bus.spi_mosi = 1'b0;
    bus.spi_cs   = 1'b0;
    #20;
  endtask

  // Clock bits [first, first+n) of word; MISO sampled at CS fall and at each falling edge.
  task automatic spi_bits(input logic [31:0] word, input int first, input int n,
                          inout logic [31:0] rd);
    for (int i = first; i < first + n; i++) begin
      if (i < 32) begin
        rd = {rd[30:0], bus.spi_miso};
        bus.spi_mosi = word[31-i];
      end else begin
        bus.spi_mosi = 1'b0;
      end
      #57 bus.spi_sck = 1'b1;
      #58 bus.spi_sck = 1'b0;
    end
  endtask

  task automatic spi_end();
    #57 bus.spi_cs = 1'b1;
  endtask

  task automatic spi_frame(input logic [31:0] word, input int nbits, output logic [31:0] rd);
    logic [31:0] acc;
    acc = '0;
    spi_start();
    spi_bits(word, 0, nbits, acc);
    spi_end();
    repeat (8) @(negedge clk);
    rd = acc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #23;
    chk("reset_miso", {31'd0, bus.spi_miso}, 32'd0);
    chk("reset_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
    chk("reset_cmd_data", bus.cmd_data, 32'd0);
    chk("reset_resp_ready", {31'd0, bus.resp_ready}, 32'd0);
    chk("reset_err_frame", {31'd0, bus.err_frame}, 32'd0);
    chk("reset_err_overrun", {31'd0, bus.err_overrun}, 32'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_resp_ready", {31'd0, bus.resp_ready}, 32'd1);
  endtask

  task automatic test_command();
    int c0 = n_cmd, f0 = n_ferr, o0 = n_oerr;
    logic [31:0] rd;
    bus.cmd_ready = 1'b1;
    spi_frame(32'hF064_04FF, 32, rd);
    chk("cmd_pulses", n_cmd - c0, 1);
    chk("cmd_data", bus.cmd_data, 32'hF064_04FF);
    chk("cmd_valid_consumed", {31'd0, bus.cmd_valid}, 32'd0);
    chk("cmd_no_err_frame", n_ferr - f0, 0);
    chk("cmd_no_err_overrun", n_oerr - o0, 0);
  endtask

  task automatic test_response();
    logic [31:0] rd;
    @(negedge clk);
    bus.resp_data  = 32'h000A_BCDE;
    bus.resp_valid = 1'b1;
    chk("resp_ready_idle", {31'd0, bus.resp_ready}, 32'd1);
    @(negedge clk);
    bus.resp_valid = 1'b0;
    chk("resp_miso_msb", {31'd0, bus.spi_miso}, 32'd0);
    spi_frame(32'h0000_0000, 32, rd);
    chk("resp_read", rd, 32'h000A_BCDE);
    spi_frame(32'h0000_0000, 32, rd);
    chk("resp_read_empty", rd, 32'h0000_0000);
  endtask

  task automatic test_bad_length();
    int c0 = n_cmd, f0 = n_ferr;
    logic [31:0] rd;
    spi_frame(32'hF064_1234, 16, rd);
    chk("short_err_frame", n_ferr - f0, 1);
    chk("short_no_cmd", n_cmd - c0, 0);
    chk("short_cmd_valid", {31'd0, bus.cmd_valid}, 32'd0);
    spi_frame(32'hF064_5678, 33, rd);
    chk("long_err_frame", n_ferr - f0, 2);
    chk("long_no_cmd", n_cmd - c0, 0);
  endtask

  task automatic test_overrun();
    int c0 = n_cmd, f0 = n_ferr, o0 = n_oerr;
    logic [31:0] rd;
    bus.cmd_ready = 1'b0;
    spi_frame(32'hF064_0011, 32, rd);
    chk("ovr_first_valid", {31'd0, bus.cmd_valid}, 32'd1);
    chk("ovr_first_data", bus.cmd_data, 32'hF064_0011);
    spi_frame(32'hF064_0010, 32, rd);
    chk("ovr_pulse", n_oerr - o0, 1);
    chk("ovr_data_kept", bus.cmd_data, 32'hF064_0011);
    chk("ovr_valid_kept", {31'd0, bus.cmd_valid}, 32'd1);
    chk("ovr_cmd_count", n_cmd - c0, 1);
    chk("ovr_no_err_frame", n_ferr - f0, 0);
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    chk("ovr_valid_cleared", {31'd0, bus.cmd_valid}, 32'd0);
  endtask

  task automatic test_resp_midframe();
    logic [31:0] rd;
    int k;
    rd = '0;
    spi_start();
    spi_bits(32'hF064_0100, 0, 16, rd);
    bus.resp_data  = 32'h1234_5678;
    bus.resp_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("mid_resp_ready_low", {31'd0, bus.resp_ready}, 32'd0);
    spi_bits(32'hF064_0100, 16, 16, rd);
    chk("mid_resp_ready_low_end", {31'd0, bus.resp_ready}, 32'd0);
    spi_end();
    k = 0;
    while (!bus.resp_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (k < 3 || k > 5) begin
      n_bad++;
      $display("FAIL mid_resp_ready_delay: got %0d negedges expected 3..5", k);
    end
    @(negedge clk);
    bus.resp_valid = 1'b0;
    chk("mid_frame_read_held_off", rd, 32'h0000_0000);
    chk("mid_cmd_data", bus.cmd_data, 32'hF064_0100);
    repeat (4) @(negedge clk);
    spi_frame(32'hF064_0101, 32, rd);
    chk("mid_next_read", rd, 32'h1234_5678);
  endtask

  task automatic test_reset_midframe();
    int c0 = n_cmd, f0 = n_ferr, o0 = n_oerr;
    logic [31:0] rd;
    rd = '0;
    spi_start();
    spi_bits(32'hF064_0200, 0, 10, rd);
    rst = 1'b0;
    #25;
    chk("rstmid_cmd_data", bus.cmd_data, 32'd0);
    chk("rstmid_miso", {31'd0, bus.spi_miso}, 32'd0);
    rst = 1'b1;
    spi_bits(32'hF064_0200, 10, 22, rd);
    spi_end();
    repeat (8) @(negedge clk);
    chk("rstmid_no_cmd", n_cmd - c0, 0);
    chk("rstmid_no_err_frame", n_ferr - f0, 0);
    chk("rstmid_no_err_overrun", n_oerr - o0, 0);
    spi_frame(32'hF064_0311, 32, rd);
    chk("rstmid_next_cmd", n_cmd - c0, 1);
    chk("rstmid_next_data", bus.cmd_data, 32'hF064_0311);
    chk("rstmid_next_no_err", n_ferr - f0, 0);
  endtask

  initial begin
    bus.spi_cs     = 1'b1;
    bus.spi_sck    = 1'b0;
    bus.spi_mosi   = 1'b0;
    bus.cmd_ready  = 1'b0;
    bus.resp_data  = '0;
    bus.resp_valid = 1'b0;
    test_reset();
    test_command();
    test_response();
    test_bad_length();
    test_overrun();
    test_resp_midframe();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
